// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// stream_mux_rr_if : handshake bundle for the N-to-1 registered stream mux
// Rev 1.0
// ============================================================================
interface stream_mux_rr_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : registered N-to-1 word mux, round-robin or fixed select
// Rev 1.0
// ============================================================================
module stream_mux_rr #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   stream_mux_rr_if.slave      bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_chan;
   logic             r_valid;

   logic             w_accept;
   logic             w_rr_valid;
   logic [SEL_W-1:0] w_rr_grant;
   logic             w_fix_valid;
   logic             w_grant_valid;
   logic [SEL_W-1:0] w_grant;
   logic [WIDTH-1:0] w_word;

   assign w_accept = !r_valid | bus.out_ready;

   // Descending scan so the lowest offset from r_ptr wins.
   always_comb begin
      w_rr_valid = 1'b0;
      w_rr_grant = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         logic [SEL_W-1:0] idx;
         idx = SEL_W'((int'(r_ptr) + k) % CHANNELS);
         if (bus.in_valid[idx]) begin
            w_rr_valid = 1'b1;
            w_rr_grant = idx;
         end
      end
   end

   always_comb begin
      w_fix_valid = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.sel == SEL_W'(i) && bus.in_valid[i])
            w_fix_valid = 1'b1;
      end
   end

   assign w_grant_valid = bus.mode ? w_fix_valid : w_rr_valid;
   assign w_grant       = bus.mode ? bus.sel    : w_rr_grant;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_grant == SEL_W'(i))
            w_word = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
      assign bus.in_ready[i] = rst_n & w_accept & w_grant_valid &
                               (w_grant == SEL_W'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_data  <= '0;
         r_chan  <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         if (w_grant_valid) begin
            r_data  <= w_word;
            r_chan  <= w_grant;
            r_valid <= 1'b1;
            if (!bus.mode)
               r_ptr <= (w_grant == c_last) ? '0 : w_grant + 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.out_data  = r_data;
   assign bus.out_chan  = r_chan;
   assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// tb_stream_mux_rr : directed vector bench for stream_mux_rr (4 x 16-bit)
// Rev 1.0
// ============================================================================
module tb_stream_mux_rr;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   stream_mux_rr_if #(.WIDTH(16), .CHANNELS(4)) bus ();

   stream_mux_rr #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_ch;
      logic [15:0] exp_d;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic [1:0] ch, input logic [15:0] d);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
      chk({tag, "_chan"},  32'(bus.out_chan),  32'(ch));
      chk({tag, "_data"},  32'(bus.out_data),  32'(d));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n         = 1'b0;
      bus.mode      = 1'b0;
      bus.sel       = 2'd0;
      bus.in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b0;

      // rotation, fairness with gaps, fixed select, mode switch
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111});
      tbl.push_back('{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222});
      tbl.push_back('{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444});
      tbl.push_back('{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222});
      tbl.push_back('{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444});
      tbl.push_back('{1'b0, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111});
      tbl.push_back('{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333});
      tbl.push_back('{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333});
      tbl.push_back('{1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3333});
      tbl.push_back('{1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3333});
      tbl.push_back('{1'b1, 2'd3, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222});
      tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111});
      tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111});
      tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333});
      tbl.push_back('{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3333});

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk_out("reset_init", 1'b0, 2'd0, 16'h0000);
      chk("reset_init_ready", 32'(bus.in_ready), 32'h0);

      for (int n = 0; n < tbl.size(); n++) begin
         bus.mode      = tbl[n].mode;
         bus.sel       = tbl[n].sel;
         bus.in_valid  = tbl[n].vld;
         bus.out_ready = tbl[n].ordy;
         #1;
         chk($sformatf("vec%0d_ready", n), 32'(bus.in_ready), 32'(tbl[n].exp_rdy));
         @(posedge clk);
         #1;
         chk_out($sformatf("vec%0d", n), tbl[n].exp_ov, tbl[n].exp_ch, tbl[n].exp_d);
      end

      // backpressure: pointer is at 3 here
      bus.mode      = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      #1;
      chk("bp_load_ready", 32'(bus.in_ready), 32'b1000);
      @(posedge clk);
      #1;
      chk_out("bp_load", 1'b1, 2'd3, 16'h4444);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_hold%0d_ready", c), 32'(bus.in_ready), 32'h0);
         @(posedge clk);
         #1;
         chk_out($sformatf("bp_hold%0d", c), 1'b1, 2'd3, 16'h4444);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'b0001);
      @(posedge clk);
      #1;
      chk_out("bp_release", 1'b1, 2'd0, 16'h1111);

      // asynchronous reset mid-stream; pointer was 1 before reset
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 2'd0, 16'h0000);
      chk("async_rst_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("async_rst_hold_ready", 32'(bus.in_ready), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'b0001);
      @(posedge clk);
      #1;
      chk_out("post_rst", 1'b1, 2'd0, 16'h1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
